methan_serializer: RTL and testbench
====================================

# methan_serializer

Parallel-to-serial front end for the methane sequence detector. It accepts WIDTH-bit sample words over a valid/ready handshake and shifts them out MSB-first, one bit per clock. Its serial output drives the detector's `din`. A one-word holding register lets consecutive words stream with no idle bit between them, so the detector sees a contiguous bit stream.

## Interface

- `WIDTH`, 8: bits per input word; legal range 2..32.
- `IDLE_BIT`, 1'b0: level driven on `dout` when no bit is valid.

- `clk`, in, 1: clock. All state is updated on the posedge.
- `arst_n`, in, 1: reset, synchronous, active-low.
- `in_data`, in, WIDTH: word to serialize. Sampled only on an accept.
- `in_valid`, in, 1: producer has a word on `in_data`.
- `in_ready`, out, 1: block can take a word. An accept occurs at a posedge where `in_valid && in_ready`.
- `dout`, out, 1: registered serial bit; feeds the detector's `din`.
- `dout_valid`, out, 1: `dout` carries a frame bit this cycle.
- `sof`, out, 1: high only during the first (MSB) bit of each frame.
- `busy`, out, 1: `shift_active || hold_full`.

## Operation

- **Storage**
  - Holding register: `hold_data`, `hold_full`.
  - Shifter: `shift_reg`, `bit_cnt` (width clog2(WIDTH+1)), FSM.
- **Ready:** `in_ready = arst_n && !hold_full`. It is combinational from registered state and does not depend on `in_valid`.
- **Accept:** `hold_data <= in_data`, `hold_full <= 1`.
- **FSM states**
  - IDLE: `dout = IDLE_BIT`, `dout_valid = 0`.
    - If `hold_full`, go to SHIFT, load `shift_reg <= hold_data`, set `bit_cnt <= WIDTH-1`, and clear `hold_full`.
  - SHIFT: `dout = shift_reg[WIDTH-1]`, `dout_valid = 1`. Each edge shifts left by one and decrements `bit_cnt`.
    - When `bit_cnt == 0`: if `hold_full`, reload directly and stay in SHIFT (no gap). Otherwise go to IDLE, or to PARITY when that feature is enabled.
  - PARITY: present only with the macro defined (see Configuration). Lasts one cycle, then takes the same exit as the SHIFT `bit_cnt == 0` case.
- **Accept during a load:** if an accept and a hold→shifter load happen on the same edge, `hold_full` stays 1 and `hold_data` takes the new word. No word is lost or duplicated.
- **sof:** high on the first SHIFT cycle after every load, and low otherwise.
- **Outputs are registered:** `dout`, `dout_valid` and `sof` come straight from flops, so the detector sees no combinational path back to `in_*`.
- **Reset** (any cycle, including mid-frame), at the next posedge:
  - FSM to IDLE, `hold_full = 0`, `shift_reg = 0`, `bit_cnt = 0`.
  - `dout = IDLE_BIT`, `dout_valid = 0`, `sof = 0`, `busy = 0`.
  - The in-flight word and the held word are discarded.
- **Accepts during reset:** none. `in_ready` is 0 while `arst_n` is low.

## Timing

- **Latency:** a word accepted at edge E0 with the shifter idle is loaded at E1. Its MSB is on `dout` in the cycle after E1, and its LSB in the cycle after E(WIDTH).
- **Throughput:** one word per WIDTH cycles sustained, or WIDTH+1 cycles with parity.
- **Ready pattern in streaming:** `in_ready` deasserts the cycle after an accept. It reasserts the cycle after the word moves into the shifter.
- **Holding the word:** the producer must keep `in_data` stable while `in_valid && !in_ready`.
- **Hold full, shifter idle:** cannot persist for more than one cycle.

## Configuration

- `METHAN_SER_PARITY_EN`
  - **Defined:** a PARITY state follows the LSB of every frame.
    - `dout` = even parity, i.e. XOR of all WIDTH data bits of the word.
    - `dout_valid` = 1, `sof` = 0.
    - Frame length is WIDTH+1. A waiting held word loads on the edge that ends PARITY.
  - **Undefined:** the PARITY state and its logic are absent, and frames are exactly WIDTH bits.

## Test plan

1. **Reset gating:** hold `arst_n = 0` for 3 cycles with `in_valid = 1`, `in_data = 8'hFF` -> `in_ready = 0`, `dout = 0`, `dout_valid = 0`, `busy = 0`, and no bits are emitted after release until a new accept.
2. **Single word:** 8'hA5 accepted at E0 -> `dout` = 1,0,1,0,0,1,0,1 in the cycles after E1..E8. `dout_valid` is high for exactly 8 cycles, `sof` only on the first, then IDLE with `dout = 0`.
3. **Streaming:** 8'hF0, 8'h0F, 8'hCC with `in_valid` held high -> 24 contiguous valid bits, `sof` every 8th cycle, `in_ready` low whenever the hold register is full.
4. **Backpressure:** `in_valid` asserted while `hold_full` -> the word waits with stable data. Each word is serialized exactly once and in order, checked with a 16-word random scoreboard.
5. **Mid-frame reset:** `arst_n` low after 3 bits of 8'h3C -> the next cycle is idle and the held word is dropped. A post-reset word 8'h81 is serialized from its MSB.
6. **Parity:** with `METHAN_SER_PARITY_EN` defined, 8'hA5 -> 8 data bits then parity 0; 8'h07 -> parity 1. Back-to-back frames are 9 cycles each with no gap.

Source files
------------

// File: rtl/methan_serializer_if.sv
// methan_serializer_if: sample-word handshake plus serial output bundle.
//   in_data/in_valid : word offered by the producer (master drives)
//   in_ready         : serializer can take a word (slave drives)
//   dout/dout_valid  : registered serial bit and its qualifier
//   sof              : first (MSB) bit of a frame
//   busy             : shifter active or holding register full
interface methan_serializer_if #(
   parameter int unsigned WIDTH = 8
) ();
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic             dout;
   logic             dout_valid;
   logic             sof;
   logic             busy;

   modport master (
      output in_data, in_valid,
      input  in_ready, dout, dout_valid, sof, busy
   );

   modport slave (
      input  in_data, in_valid,
      output in_ready, dout, dout_valid, sof, busy
   );
endinterface

// File: rtl/methan_serializer.sv
// methan_serializer: parallel-to-serial front end for the methane sequence
// detector. WIDTH-bit words arrive over a valid/ready handshake, pass through a
// one-word holding register and are shifted out MSB-first, one bit per clock.
// Back-to-back words produce a contiguous bit stream.
//   clk    : clock, all state on posedge
//   arst_n : synchronous active-low reset
//   bus    : methan_serializer_if.slave (in_data, in_valid, in_ready, dout,
//            dout_valid, sof, busy)
// Optional feature: define METHAN_SER_PARITY_EN to append an even-parity bit
// after the LSB of every frame (frame length WIDTH+1).
module methan_serializer #(
   parameter int unsigned WIDTH    = 8,
   parameter logic        IDLE_BIT = 1'b0
) (
   input logic                clk,
   input logic                arst_n,
   methan_serializer_if.slave bus
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);

`ifdef METHAN_SER_PARITY_EN
   typedef enum logic [1:0] {StIdle, StShift, StParity} state_e;
`else
   typedef enum logic [1:0] {StIdle, StShift} state_e;
`endif

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  shift_q, shift_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]  hold_data_q, hold_data_d;
   logic              hold_full_q, hold_full_d;
   logic              dout_q, dout_d;
   logic              dout_valid_q, dout_valid_d;
   logic              sof_q, sof_d;
   logic              accept, load, end_frame;
`ifdef METHAN_SER_PARITY_EN
   logic              par_q, par_d;
`endif

   assign bus.in_ready   = arst_n && !hold_full_q;
   assign bus.dout       = dout_q;
   assign bus.dout_valid = dout_valid_q;
   assign bus.sof        = sof_q;
   assign bus.busy       = (state_q != StIdle) || hold_full_q;

   always_comb begin
      accept      = bus.in_valid && bus.in_ready;
      load        = 1'b0;
      end_frame   = 1'b0;
      state_d     = state_q;
      shift_d     = shift_q;
      cnt_d       = cnt_q;
      hold_data_d = hold_data_q;
      hold_full_d = hold_full_q;

      unique case (state_q)
         StIdle: begin
            if (hold_full_q) load = 1'b1;
         end
         StShift: begin
            shift_d = {shift_q[WIDTH-2:0], 1'b0};
            if (cnt_q == '0) begin
`ifdef METHAN_SER_PARITY_EN
               state_d = StParity;
`else
               end_frame = 1'b1;
`endif
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
`ifdef METHAN_SER_PARITY_EN
         StParity: end_frame = 1'b1;
`endif
         default: state_d = StIdle;
      endcase

      // A waiting word reloads on the frame's last edge so no idle bit appears.
      if (end_frame) begin
         if (hold_full_q) load = 1'b1;
         else             state_d = StIdle;
      end

      if (load) begin
         state_d     = StShift;
         shift_d     = hold_data_q;
         cnt_d       = CntW'(WIDTH - 1);
         hold_full_d = 1'b0;
      end

      // Accept wins over the load's clear so a same-edge word is never lost.
      if (accept) begin
         hold_full_d = 1'b1;
         hold_data_d = bus.in_data;
      end

`ifdef METHAN_SER_PARITY_EN
      par_d = load ? ^hold_data_q : par_q;
`endif

      // Outputs are computed from next state so they leave the block as flops.
      dout_valid_d = (state_d != StIdle);
      sof_d        = load;
      unique case (state_d)
         StShift:  dout_d = shift_d[WIDTH-1];
`ifdef METHAN_SER_PARITY_EN
         StParity: dout_d = par_d;
`endif
         default:  dout_d = IDLE_BIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!arst_n) begin
         state_q      <= StIdle;
         shift_q      <= '0;
         cnt_q        <= '0;
         hold_data_q  <= '0;
         hold_full_q  <= 1'b0;
         dout_q       <= IDLE_BIT;
         dout_valid_q <= 1'b0;
         sof_q        <= 1'b0;
`ifdef METHAN_SER_PARITY_EN
         par_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         cnt_q        <= cnt_d;
         hold_data_q  <= hold_data_d;
         hold_full_q  <= hold_full_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         sof_q        <= sof_d;
`ifdef METHAN_SER_PARITY_EN
         par_q        <= par_d;
`endif
      end
   end

endmodule

// File: tb/tb_methan_serializer.sv
// tb_methan_serializer: scoreboard bench for methan_serializer. Each accepted
// word pushes its expected serial bits (and sof flags) into a queue; a monitor
// on the falling edge pops and compares whenever dout_valid is high, and checks
// idle levels otherwise.
module tb_methan_serializer;

   localparam int unsigned W = 8;
`ifdef METHAN_SER_PARITY_EN
   localparam int unsigned FL = W + 1;
`else
   localparam int unsigned FL = W;
`endif
   localparam int Budget = 400;

   logic clk = 1'b0;
   logic arst_n = 1'b0;
   always #5 clk = ~clk;

   methan_serializer_if #(.WIDTH(W)) bus ();

   methan_serializer #(
      .WIDTH    (W),
      .IDLE_BIT (1'b0)
   ) dut (
      .clk    (clk),
      .arst_n (arst_n),
      .bus    (bus)
   );

   typedef struct packed {
      logic b;
      logic s;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   checks = 0;
   int   errors = 0;
   int   pop_cnt = 0;
   int   cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: compares every valid bit against the scoreboard head.
   always @(negedge clk) begin
      if (bus.dout_valid === 1'b1) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_bit: got dout_valid=1 required 0 (cycle %0d)", cyc);
         end else begin
            e = q.pop_front();
            check("dout_bit", int'(bus.dout), int'(e.b));
            check("sof", int'(bus.sof), int'(e.s));
            pop_cnt++;
         end
      end else begin
         check("idle_dout", int'(bus.dout), 0);
         check("idle_sof", int'(bus.sof), 0);
      end
   end

   task automatic push_word(input logic [W-1:0] w);
      exp_t x;
      for (int i = W - 1; i >= 0; i--) begin
         x.b = w[i];
         x.s = (i == W - 1);
         q.push_back(x);
      end
`ifdef METHAN_SER_PARITY_EN
      x.b = ^w;
      x.s = 1'b0;
      q.push_back(x);
`endif
   endtask

   // Offer a word, hold it stable until accepted, leave in_valid high.
   task automatic send(input logic [W-1:0] w);
      int n = 0;
      bus.in_data  = w;
      bus.in_valid = 1'b1;
      @(negedge clk);
      while (bus.in_ready !== 1'b1 && n < Budget) begin
         n++;
         @(negedge clk);
      end
      if (n >= Budget) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got in_ready=0 required 1 for word %0h", w);
         bus.in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      push_word(w);
      #1;
      check("ready_drop", int'(bus.in_ready), 0);
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((q.size() != 0 || bus.busy === 1'b1) && n < Budget) begin
         n++;
         @(posedge clk);
         #1;
      end
      if (n >= Budget) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d bits pending required 0", q.size());
      end
      @(posedge clk);
      #1;
   endtask

   // Stream up to three words with in_valid held high, verify no gaps.
   task automatic stream_words(input logic [W-1:0] w0, input logic [W-1:0] w1,
                               input logic [W-1:0] w2, input int cnt);
      int base = pop_cnt;
      int t0 = 0;
      int t1 = 0;
      fork
         begin
            send(w0);
            send(w1);
            if (cnt > 2) send(w2);
            bus.in_valid = 1'b0;
         end
         begin
            int n = 0;
            while (pop_cnt == base && n < Budget) begin
               n++;
               @(posedge clk);
               #1;
            end
            t0 = cyc;
            while (pop_cnt < base + cnt * int'(FL) && n < Budget) begin
               n++;
               @(posedge clk);
               #1;
            end
            t1 = cyc;
         end
      join
      check("stream_span", t1 - t0, cnt * int'(FL) - 1);
      wait_drain();
   endtask

   initial begin
      int base;
      int n;
      logic [W-1:0] w;

      // Reset gating
      arst_n       = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hFF;
      repeat (3) begin
         @(negedge clk);
         check("rst_in_ready", int'(bus.in_ready), 0);
         check("rst_dout_valid", int'(bus.dout_valid), 0);
         check("rst_busy", int'(bus.busy), 0);
         check("rst_dout", int'(bus.dout), 0);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      arst_n       = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("post_rst_busy", int'(bus.busy), 0);

      // Single word: MSB appears the cycle after the load edge
      base = pop_cnt;
      send(8'hA5);
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("latency_idle", int'(bus.dout_valid), 0);
      @(negedge clk);
      check("latency_first", int'(bus.dout_valid), 1);
      wait_drain();
      check("single_count", pop_cnt - base, int'(FL));
      check("single_idle_valid", int'(bus.dout_valid), 0);
      check("single_idle_dout", int'(bus.dout), 0);

      // Streaming
      stream_words(8'hF0, 8'h0F, 8'hCC, 3);

      // Backpressure with random words and gaps
      base = pop_cnt;
      for (int i = 0; i < 16; i++) begin
         w = W'($urandom);
         send(w);
         if ($urandom_range(0, 1) == 0) begin
            bus.in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
         end
      end
      bus.in_valid = 1'b0;
      wait_drain();
      check("random_count", pop_cnt - base, 16 * int'(FL));

      // Mid-frame reset drops both the in-flight and the held word
      base = pop_cnt;
      send(8'h3C);
      send(8'h55);
      bus.in_valid = 1'b0;
      n = 0;
      while (pop_cnt < base + 3 && n < Budget) begin
         n++;
         @(posedge clk);
         #1;
      end
      arst_n = 1'b0;
      @(posedge clk);
      #1;
      q.delete();
      check("midrst_valid", int'(bus.dout_valid), 0);
      check("midrst_busy", int'(bus.busy), 0);
      check("midrst_ready", int'(bus.in_ready), 0);
      arst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("midrst_hold_dropped", int'(bus.busy), 0);
      base = pop_cnt;
      send(8'h81);
      bus.in_valid = 1'b0;
      wait_drain();
      check("post_rst_count", pop_cnt - base, int'(FL));

      // Parity frames (A5 -> 0, 07 -> 1) back-to-back; plain frames otherwise
      stream_words(8'hA5, 8'h07, 8'h00, 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no end of test required $finish");
      $fatal(1, "watchdog expired");
   end

endmodule
